// File: rtl/tracker_pkg.sv
// Shared types and constants for the colour-tracker post-processing blocks.
package tracker_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV_X,
        S_DIV_Y,
        S_DIV_R,
        S_PUBLISH,
        S_NO_TARGET
    } state_t;

    localparam int DIV_CYCLES = 32;
    localparam int R_NUM      = 7;
    localparam int R_DEN      = 22;
    localparam int DROP_W     = 8;

endpackage

// File: rtl/serial_divider.sv
// 32-bit unsigned restoring divider, one quotient bit per clock.
module serial_divider #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic        done
);

    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic [5:0]  r_cnt;
    logic        r_run;
    logic        r_done;

    logic [31:0] w_rem_in;
    logic [31:0] w_quo_in;
    logic [31:0] w_div_in;
    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;

    // The first iteration runs in the start cycle so the quotient
    // is ready exactly DIV_CYCLES cycles after start is sampled.
    assign w_rem_in = start ? 32'd0    : r_rem;
    assign w_quo_in = start ? dividend : r_quo;
    assign w_div_in = start ? divisor  : r_div;
    assign w_trial  = {w_rem_in, w_quo_in[31]};
    assign w_ge     = w_trial[32] | (w_trial[31:0] >= w_div_in);
    assign w_rem_nx = w_ge ? (w_trial[31:0] - w_div_in) : w_trial[31:0];
    assign w_quo_nx = {w_quo_in[30:0], w_ge};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_div <= divisor;
                r_cnt <= 6'(DIV_CYCLES - 1);
                r_run <= 1'b1;
            end else if (r_run) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_quo;
    assign done     = r_done;

endmodule

// File: rtl/centroid_scheduler.sv
// End-of-frame controller: runs x/y centroid and radius divisions
// through one shared serial divider and publishes the results.
module centroid_scheduler
    import tracker_pkg::*;
#(
    parameter int MIN_SIZE   = 16,
    parameter int DIV_CYCLES = tracker_pkg::DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_done,
    input  logic [31:0] size,
    input  logic [31:0] sum_x,
    input  logic [31:0] sum_y,
    output logic [31:0] x_center,
    output logic [31:0] y_center,
    output logic [31:0] r_squared,
    output logic        target_found,
    output logic        result_valid,
    output logic        busy,
    output logic [7:0]  drop_count
);

    state_t r_state;
    state_t w_next;

    logic [31:0] r_size;
    logic [31:0] r_sx;
    logic [31:0] r_sy;
    logic [31:0] r_hold_x;
    logic [31:0] r_hold_y;

    logic        w_start;
    logic [31:0] w_dividend;
    logic [31:0] w_divisor;
    logic [31:0] w_quotient;
    logic        w_done;
    logic        w_small;
    logic [34:0] w_rnum_full;
    logic [31:0] w_rnum;

    assign w_small     = r_size < 32'(MIN_SIZE);
    assign w_rnum_full = {3'b000, r_size} * 35'(R_NUM);
    assign w_rnum      = (|w_rnum_full[34:32]) ? 32'hFFFF_FFFF
                                               : w_rnum_full[31:0];

    serial_divider #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_start),
        .dividend (w_dividend),
        .divisor  (w_divisor),
        .quotient (w_quotient),
        .done     (w_done)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (frame_done) w_next = S_CHECK;
            S_CHECK:     w_next = w_small ? S_NO_TARGET : S_DIV_X;
            S_DIV_X:     if (w_done) w_next = S_DIV_Y;
            S_DIV_Y:     if (w_done) w_next = S_DIV_R;
            S_DIV_R:     if (w_done) w_next = S_PUBLISH;
            S_PUBLISH:   w_next = S_IDLE;
            S_NO_TARGET: w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start      = 1'b0;
        w_dividend   = r_sx;
        w_divisor    = r_size;
        busy         = r_state != S_IDLE;
        result_valid = (r_state == S_PUBLISH) || (r_state == S_NO_TARGET);
        unique case (r_state)
            S_CHECK: w_start = !w_small;
            S_DIV_X: begin
                w_start    = w_done;
                w_dividend = r_sy;
            end
            S_DIV_Y: begin
                w_start    = w_done;
                w_dividend = w_rnum;
                w_divisor  = 32'(R_DEN);
            end
            default: ;
        endcase
    end

    // Outputs are loaded on the edge entering PUBLISH/NO_TARGET so they
    // change in the same cycle as the result_valid strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_size       <= '0;
            r_sx         <= '0;
            r_sy         <= '0;
            r_hold_x     <= '0;
            r_hold_y     <= '0;
            x_center     <= '0;
            y_center     <= '0;
            r_squared    <= '0;
            target_found <= 1'b0;
            drop_count   <= '0;
        end else begin
            if (r_state == S_IDLE && frame_done) begin
                r_size <= size;
                r_sx   <= sum_x;
                r_sy   <= sum_y;
            end
            if (r_state != S_IDLE && frame_done
                && drop_count != {DROP_W{1'b1}})
                drop_count <= drop_count + 8'd1;
            if (r_state == S_DIV_X && w_done) r_hold_x <= w_quotient;
            if (r_state == S_DIV_Y && w_done) r_hold_y <= w_quotient;
            if (r_state == S_DIV_R && w_done) begin
                x_center     <= r_hold_x;
                y_center     <= r_hold_y;
                r_squared    <= w_quotient;
                target_found <= 1'b1;
            end
            if (r_state == S_CHECK && w_small) target_found <= 1'b0;
        end
    end

endmodule

// File: tb/tb_centroid_scheduler.sv
// Directed scoreboard bench for centroid_scheduler.
module tb_centroid_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_done;
    logic [31:0] size;
    logic [31:0] sum_x;
    logic [31:0] sum_y;
    logic [31:0] x_center;
    logic [31:0] y_center;
    logic [31:0] r_squared;
    logic        target_found;
    logic        result_valid;
    logic        busy;
    logic [7:0]  drop_count;

    centroid_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .frame_done   (frame_done),
        .size         (size),
        .sum_x        (sum_x),
        .sum_y        (sum_y),
        .x_center     (x_center),
        .y_center     (y_center),
        .r_squared    (r_squared),
        .target_found (target_found),
        .result_valid (result_valid),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cycle;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic        found;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mx = 0;
    logic [31:0] my = 0;
    logic [31:0] mr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] s, input logic [31:0] x,
                        input logic [31:0] y, input bit push);
        exp_t        e;
        logic [34:0] p;
        logic [31:0] rn;
        frame_done = 1'b1;
        size  = s;
        sum_x = x;
        sum_y = y;
        if (push) begin
            if (s < 16) begin
                e.cycle = cyc + 2;
                e.found = 1'b0;
            end else begin
                p  = {3'b000, s} * 35'd7;
                rn = (p[34:32] != 3'b000) ? 32'hFFFF_FFFF : p[31:0];
                mx = x / s;
                my = y / s;
                mr = rn / 32'd22;
                e.cycle = cyc + 98;
                e.found = 1'b1;
            end
            e.x = mx;
            e.y = my;
            e.r = mr;
            sb.push_back(e);
        end
        tick();
        frame_done = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        bit   seen;
        seen = 0;
        for (int n = 0; n < 200 && !seen; n++) begin
            if (result_valid) seen = 1;
            else tick();
        end
        if (!seen) begin
            chk({tag, "_timeout"}, {31'd0, result_valid}, 32'd1);
        end else if (sb.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(sb.size()), 32'd1);
            tick();
        end else begin
            e = sb.pop_front();
            chk({tag, "_cycle"}, 32'(cyc), 32'(e.cycle));
            chk({tag, "_x"}, x_center, e.x);
            chk({tag, "_y"}, y_center, e.y);
            chk({tag, "_r"}, r_squared, e.r);
            chk({tag, "_found"}, {31'd0, target_found}, {31'd0, e.found});
            tick();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, x_center, 0);
        chk({tag, "_y"}, y_center, 0);
        chk({tag, "_r"}, r_squared, 0);
        chk({tag, "_found"}, {31'd0, target_found}, 0);
        chk({tag, "_valid"}, {31'd0, result_valid}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_drop"}, {24'd0, drop_count}, 0);
    endtask

    initial begin
        int  c0;
        bit  bad;
        reset      = 1'b1;
        frame_done = 1'b0;
        size       = 0;
        sum_x      = 0;
        sum_y      = 0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_zero("reset");

        send(100, 40000, 30000, 1);
        chk("nominal_busy_rise", {31'd0, busy}, 1);
        wait_result("nominal");
        chk("nominal_busy_fall", {31'd0, busy}, 0);

        send(10, 5, 5, 1);
        wait_result("small");
        chk("small_busy_fall", {31'd0, busy}, 0);

        c0 = cyc;
        send(100, 40000, 30000, 1);
        while (cyc < c0 + 50) tick();
        frame_done = 1'b1;
        size  = 50;
        sum_x = 1000;
        sum_y = 1000;
        tick();
        frame_done = 1'b0;
        wait_result("drop");
        chk("drop_one", {24'd0, drop_count}, 1);

        for (int f = 0; f < 4; f++) begin
            send(100 + f, 40000, 30000, 1);
            for (int k = 0; k < 90; k++) begin
                frame_done = 1'b1;
                size  = 7;
                sum_x = 7;
                sum_y = 7;
                tick();
            end
            frame_done = 1'b0;
            wait_result("drop_burst");
            if (f == 0) chk("drop_91", {24'd0, drop_count}, 91);
        end
        chk("drop_sat", {24'd0, drop_count}, 255);

        c0 = cyc;
        send(200, 20000, 10000, 0);
        while (cyc < c0 + 40) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("midreset");
        mx = 0;
        my = 0;
        mr = 0;
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            if (result_valid) bad = 1;
            tick();
        end
        chk("midreset_no_valid", {31'd0, bad}, 0);

        send(200, 20000, 10000, 1);
        wait_result("post_reset");

        send(32'h3000_0000, 0, 0, 1);
        wait_result("sat");

        send(16, 17, 15, 1);
        wait_result("boundary");

        send(15, 17, 15, 1);
        wait_result("below_min");

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
